pulse_width_ctrl: RTL and testbench

//  Armed single-shot pulse-width measurement controller for an asynchronous level input.

---
 rtl/pulse_width_pkg.sv | 14 +
 rtl/pulse_width_ctrl_edge.sv | 40 ++++
 rtl/pulse_width_ctrl.sv | 99 +++++++++
 tb/tb_pulse_width_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_pkg.sv
// Shared types and default sizing for the pulse-width measurement controller.
package pulse_width_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } pw_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_width_ctrl_edge.sv
// Synchroniser chain plus registered rise/fall strobes for one asynchronous level.
module edge_detect
  import pulse_width_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // rise and fall compare the same s/s_d pair, so they are mutually exclusive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d_q  <= s;
      rise_q <= s & ~s_d_q;
      fall_q <= ~s & s_d_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pulse_width_ctrl.sv
// Armed single-shot pulse-width measurement: sync/edge front end feeding an
// IDLE->ARMED->MEASURE->REPORT sequencer with a saturating width counter.
//
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | waiting for a fresh synchronised rising edge
//   MEASURE | counting high cycles until fall or saturation
//   REPORT  | result held on width/timeout until accepted
module pulse_width_ctrl
  import pulse_width_pkg::*;
#(
  parameter int               SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] MAX_WIDTH   = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic             arm,
  output logic             busy,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] width,
  output logic             timeout,
  output logic             width_valid,
  input  logic             width_ready
);

  pw_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             timeout_q, timeout_d;

  edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk (clk),
    .rst (rst),
    .d   (signal),
    .rise(rise_pulse),
    .fall(fall_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      width_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (rise_pulse) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        // a fall coinciding with saturation still reports a real width
        if (fall_pulse) begin
          state_d   = REPORT;
          width_d   = cnt_q;
          timeout_d = 1'b0;
        end else if (cnt_q == MAX_WIDTH) begin
          state_d   = REPORT;
          width_d   = MAX_WIDTH;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPORT: begin
        if (width_ready) state_d = arm ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign width_valid = (state_q == REPORT);
  assign width       = width_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pulse_width_ctrl.sv
// Directed bench for pulse_width_ctrl: two instances (full-range and MAX_WIDTH=50)
// share stimulus and are checked every cycle against an edge-index model.
module tb_pulse_width_ctrl;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst, signal, arm, width_ready;
  logic busy_a, rise_a, fall_a, to_a, vld_a;
  logic busy_b, rise_b, fall_b, to_b, vld_b;
  logic [15:0] w_a, w_b;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  pulse_width_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(16), .MAX_WIDTH(16'hFFFF)) dut_a (
    .clk(clk), .rst(rst), .signal(signal), .arm(arm), .busy(busy_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .width(w_a), .timeout(to_a),
    .width_valid(vld_a), .width_ready(width_ready)
  );

  pulse_width_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(16), .MAX_WIDTH(16'd50)) dut_b (
    .clk(clk), .rst(rst), .signal(signal), .arm(arm), .busy(busy_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .width(w_b), .timeout(to_b),
    .width_valid(vld_b), .width_ready(width_ready)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s @%0t actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  // Model: measurement length is the distance in clock edges between the edge
  // that sees the rise strobe and the edge that sees the fall strobe.
  function automatic int maxw(input int i);
    return (i == 0) ? 65535 : 50;
  endfunction

  bit smp [0:SYNC+1];
  bit rise_e, fall_e;
  int k;
  int mode [2];   // 0 idle, 1 armed, 2 measuring, 3 reporting
  int kr [2];
  int wexp [2];
  bit toexp [2];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int j = 0; j <= SYNC + 1; j++) smp[j] = 1'b0;
        rise_e = 1'b0;
        fall_e = 1'b0;
        k = 0;
        for (int i = 0; i < 2; i++) begin
          mode[i] = 0; kr[i] = 0; wexp[i] = 0; toexp[i] = 1'b0;
        end
      end else begin
        bit pr, pf;
        pr = rise_e;
        pf = fall_e;
        k++;
        for (int j = SYNC + 1; j > 0; j--) smp[j] = smp[j-1];
        smp[0] = signal;
        rise_e = smp[SYNC] && !smp[SYNC+1];
        fall_e = !smp[SYNC] && smp[SYNC+1];
        for (int i = 0; i < 2; i++) begin
          case (mode[i])
            0: if (arm) mode[i] = 1;
            1: if (pr) begin mode[i] = 2; kr[i] = k; end
            2: begin
              if (pf) begin
                mode[i] = 3; wexp[i] = k - kr[i]; toexp[i] = 1'b0;
              end else if (k - kr[i] == maxw(i)) begin
                mode[i] = 3; wexp[i] = maxw(i); toexp[i] = 1'b1;
              end
            end
            default: if (width_ready) mode[i] = arm ? 1 : 0;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("a busy",   int'(busy_a), int'(mode[0] != 0));
      chk("a valid",  int'(vld_a),  int'(mode[0] == 3));
      chk("a rise",   int'(rise_a), int'(rise_e));
      chk("a fall",   int'(fall_a), int'(fall_e));
      chk("a width",  int'(w_a),    wexp[0]);
      chk("a timeout",int'(to_a),   int'(toexp[0]));
      chk("b busy",   int'(busy_b), int'(mode[1] != 0));
      chk("b valid",  int'(vld_b),  int'(mode[1] == 3));
      chk("b rise",   int'(rise_b), int'(rise_e));
      chk("b fall",   int'(fall_b), int'(fall_e));
      chk("b width",  int'(w_b),    wexp[1]);
      chk("b timeout",int'(to_b),   int'(toexp[1]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    signal = 1'b1;
    cyc(n);
    signal = 1'b0;
  endtask

  task automatic arm_once();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    cyc(3);
  endtask

  task automatic wait_valid(input int i, input int lim);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk);
      if ((i == 0) ? vld_a : vld_b) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_valid dut%0d actual=no_valid required=valid_within_%0d", i, lim);
    end
  endtask

  initial begin
    int n;
    int vcount;
    rst = 1'b1; signal = 1'b0; arm = 1'b0; width_ready = 1'b0;

    // 1: reset with input high mid-reset
    #50 signal = 1'b1;
    #5;
    chk("rst busy",  int'(busy_a), 0);
    chk("rst rise",  int'(rise_a), 0);
    chk("rst valid", int'(vld_a),  0);
    chk("rst width", int'(w_a),    0);
    chk("rst to",    int'(to_a),   0);
    chk("rst b busy",int'(busy_b), 0);
    cyc(3);
    rst = 1'b0;
    cyc(1); chk("post rst rise e1", int'(rise_a), 0);
    cyc(1); chk("post rst rise e2", int'(rise_a), 0);
    cyc(1); chk("post rst rise e3", int'(rise_a), 1);
    signal = 1'b0;
    cyc(10);

    // 2: basic 125-cycle measurement with ready held
    width_ready = 1'b1;
    arm_once();
    pulse(125);
    wait_valid(0, 20);
    chk("t2 width", int'(w_a), 125);
    chk("t2 to",    int'(to_a), 0);
    cyc(1);
    chk("t2 valid one cycle", int'(vld_a), 0);
    chk("t2 b width sat", int'(w_b), 50);
    chk("t2 b to",        int'(to_b), 1);
    cyc(5);

    // 3: result held while consumer stalls, input toggling
    width_ready = 1'b0;
    arm_once();
    pulse(30);
    wait_valid(0, 20);
    for (int t = 0; t < 5; t++) begin
      signal = 1'b1; cyc(1);
      signal = 1'b0; cyc(1);
    end
    cyc(4);
    chk("t3 width held", int'(w_a), 30);
    chk("t3 to held",    int'(to_a), 0);
    chk("t3 valid held", int'(vld_a), 1);
    chk("t3 b width",    int'(w_b), 30);
    width_ready = 1'b1;
    cyc(1);
    chk("t3 a idle", int'(busy_a), 0);
    chk("t3 b idle", int'(busy_b), 0);
    cyc(3);

    // 4: saturation at MAX_WIDTH=50
    arm_once();
    signal = 1'b1;
    n = 0;
    while (!rise_b && n < 10) begin cyc(1); n++; end
    chk("t4 rise seen", int'(rise_b), 1);
    n = 0;
    while (!vld_b && n < 100) begin cyc(1); n++; end
    chk("t4 cycles rise->valid", n, 51);
    chk("t4 b width", int'(w_b), 50);
    chk("t4 b to",    int'(to_b), 1);
    cyc(250 - 3 - 51);
    signal = 1'b0;
    wait_valid(0, 20);
    chk("t4 a width", int'(w_a), 250);
    cyc(5);

    // boundary: fall coincides with saturation, then one past it
    arm_once();
    pulse(50);
    wait_valid(1, 20);
    chk("edge50 b width", int'(w_b), 50);
    chk("edge50 b to",    int'(to_b), 0);
    cyc(5);
    arm_once();
    pulse(51);
    cyc(10);
    chk("edge51 b to", int'(to_b), 1);
    chk("edge51 a width", int'(w_a), 51);

    // 5: arm while input already high
    signal = 1'b1;
    cyc(10);
    arm_once();
    cyc(20);
    chk("t5 still armed", int'(busy_a), 1);
    chk("t5 no result",   int'(vld_a), 0);
    signal = 1'b0;
    cyc(10);
    pulse(125);
    wait_valid(0, 20);
    chk("t5 width", int'(w_a), 125);
    cyc(5);

    // 6: back-to-back with arm held, then reset during measurement
    arm = 1'b1;
    cyc(3);
    pulse(40);
    wait_valid(0, 20);
    chk("t6 first", int'(w_a), 40);
    cyc(5);
    pulse(60);
    wait_valid(0, 20);
    chk("t6 second", int'(w_a), 60);
    cyc(5);
    signal = 1'b1;
    cyc(30);
    chk("t6 measuring", int'(busy_a), 1);
    #5 rst = 1'b1;
    arm = 1'b0;
    cyc(3);
    #5 rst = 1'b0;
    cyc(1);
    chk("t6 width cleared", int'(w_a), 0);
    vcount = 0;
    for (int t = 0; t < 80; t++) begin
      cyc(1);
      if (vld_a || vld_b) vcount++;
    end
    chk("t6 no valid after rst", vcount, 0);
    signal = 1'b0;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
